// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator: 50 MHz clock, divide-by-2 pixel tick,
// active-low syncs, visible-area coordinates and display-active flag.
module vga_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hSync,
  output logic       vSync,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       displayActive
);

  localparam int unsigned HW      = 10;
  localparam int unsigned VW      = 10;
  localparam int unsigned RW      = 9;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic          tick_q, tick_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] col_q, col_d;

  // Outputs are decoded from the next counter values and registered, so they
  // move only on the edge that moves the counters and cannot glitch.
  always_comb begin
    tick_d = ~tick_q;
    h_d    = h_q;
    v_d    = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
    hsync_d  = ~((h_d >= H_SYNC_S) && (h_d <= H_SYNC_E));
    vsync_d  = ~((v_d >= V_SYNC_S) && (v_d <= V_SYNC_E));
    active_d = (h_d < H_VIS) && (v_d < V_VIS);
    col_d    = (h_d < H_VIS) ? h_d : '0;
    row_d    = (v_d < V_VIS) ? RW'(v_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q   <= 1'b1;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b1;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      tick_q   <= tick_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign hSync         = hsync_q;
  assign vSync         = vsync_q;
  assign displayActive = active_q;
  assign row           = row_q;
  assign column        = col_q;

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller: full horizontal timing, shortened
// vertical timing (13-line frame) so a frame wrap fits in a short run.
module tb_vga_controller;

  localparam int unsigned VV = 6;
  localparam int unsigned VF = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned VT = VV + VF + VS + VB;

  // Hand-computed edge numbers (edge 1 = first rising edge after release).
  localparam int HS_FALL   = 1311;
  localparam int HS_RISE   = 1503;
  localparam int LINE_CLK  = 1600;
  localparam int VS_FALL   = 12799;  // 800*8 increments -> edge 2*6400-1
  localparam int VS_RISE   = 15999;  // two lines later
  localparam int FRAME_CLK = 20800;  // 13 lines * 1600

  logic       clk;
  logic       rst;
  logic       hSync, vSync, displayActive;
  logic [8:0] row;
  logic [9:0] column;

  vga_controller #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .hSync(hSync), .vSync(vSync),
    .row(row), .column(column), .displayActive(displayActive)
  );

  typedef struct {
    logic       hs;
    logic       vs;
    logic       da;
    logic [8:0] row;
    logic [9:0] col;
    int         edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_falls = 0;
  int   vs_falls = 0;
  bit   done = 0;

  bit m_tick;
  int m_h, m_v, edge_n;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input int edge_no, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_no, act, req);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.hs     = !(m_h >= 656 && m_h <= 751);
    e.vs     = !(m_v >= int'(VV + VF) && m_v <= int'(VV + VF + 1));
    e.da     = (m_h < 640) && (m_v < int'(VV));
    e.col    = (m_h < 640) ? 10'(m_h) : 10'd0;
    e.row    = (m_v < int'(VV)) ? 9'(m_v) : 9'd0;
    e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  // One clock: advance the model if out of reset, then set rst 5 ns after the edge.
  task automatic cycle(input logic rst_after);
    @(posedge clk);
    if (rst) begin
      edge_n++;
      if (m_tick) begin
        if (m_h == 799) begin
          m_h = 0;
          m_v = (m_v == int'(VT) - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
      m_tick = !m_tick;
    end
    #5;
    if (!rst_after) begin
      m_tick = 1'b1;
      m_h    = 0;
      m_v    = 0;
      edge_n = 0;
    end
    rst = rst_after;
    push_exp();
  endtask

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t e;
    logic prev_hs, prev_vs;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hSync",         e.edge_n, int'(hSync),         int'(e.hs));
        chk("vSync",         e.edge_n, int'(vSync),         int'(e.vs));
        chk("displayActive", e.edge_n, int'(displayActive), int'(e.da));
        chk("row",           e.edge_n, int'(row),           int'(e.row));
        chk("column",        e.edge_n, int'(column),        int'(e.col));
        if (e.edge_n > 0) begin
          if (hSync !== prev_hs) begin
            if (!hSync) begin
              hs_falls++;
              chk("hsync_fall_edge", e.edge_n, e.edge_n % LINE_CLK, HS_FALL);
            end else begin
              chk("hsync_rise_edge", e.edge_n, e.edge_n % LINE_CLK, HS_RISE);
            end
          end
          if (vSync !== prev_vs) begin
            if (!vSync) begin
              vs_falls++;
              chk("vsync_fall_edge", e.edge_n, e.edge_n % FRAME_CLK, VS_FALL);
            end else begin
              chk("vsync_rise_edge", e.edge_n, e.edge_n % FRAME_CLK, VS_RISE);
            end
          end
        end
        prev_hs = hSync;
        prev_vs = vSync;
      end
    end
  end

  initial begin
    m_tick = 1'b1;
    m_h    = 0;
    m_v    = 0;
    edge_n = 0;
    rst    = 1'b1;
    #1 rst = 1'b0;

    // Held in reset: outputs must sit at reset values.
    repeat (20) cycle(1'b0);
    cycle(1'b1);
    // Through one frame wrap and into the second frame; stop inside hSync low.
    repeat (38200) cycle(1'b1);
    // Asynchronous reset mid-line during hSync low, compared before the next edge.
    cycle(1'b0);
    repeat (50) cycle(1'b0);
    cycle(1'b1);
    // Timing restarts from edge 1.
    repeat (16500) cycle(1'b1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 0, sb.size(), 0);
    chk("hsync_fall_count",   0, hs_falls, 34);
    chk("vsync_fall_count",   0, vs_falls, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
